// File: rtl/stm32_bus_master.sv
// Initiator for the 8-bit DATA_BUS/DATA_SYNC link: sends a command byte, streams its fixed payload.
// Optional build macro BUS_MASTER_TEST_EN enables the cmd-0 bus echo test; without it cmd 0 is rejected.

module stm32_bus_master (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_cmd,
    output logic       req_ready,
    input  logic [7:0] wr_data,
    output logic       wr_take,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       err,
    output logic       test_fail,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       data_sync
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TURN  = 3'd1,
        S_CMD   = 3'd2,
        S_WR    = 3'd3,
        S_RWAIT = 3'd4,
        S_RD    = 3'd5,
        S_GAP   = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    function automatic logic [4:0] wr_len(input logic [2:0] cmd);
        case (cmd)
            3'd0:    wr_len = 5'd1;
            3'd1:    wr_len = 5'd12;
            3'd3:    wr_len = 5'd8;
            default: wr_len = 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] rd_len(input logic [2:0] cmd);
        case (cmd)
            3'd0:    rd_len = 5'd1;
            3'd2:    rd_len = 5'd5;
            3'd4:    rd_len = 5'd16;
            default: rd_len = 5'd0;
        endcase
    endfunction

    function automatic logic cmd_ok(input logic [2:0] cmd);
`ifdef BUS_MASTER_TEST_EN
        cmd_ok = (cmd != 3'd7);
`else
        cmd_ok = (cmd != 3'd7) && (cmd != 3'd0);
`endif
    endfunction

    state_t     state_q, state_d;
    logic [2:0] cmd_q, cmd_d;
    logic [4:0] cnt_q, cnt_d;
    logic       last_rd_q, last_rd_d;
    logic       req_ready_q, req_ready_d;
    logic       wr_take_q, wr_take_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       test_fail_q, test_fail_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic       bus_oe_q, bus_oe_d;
    logic       data_sync_q, data_sync_d;
`ifdef BUS_MASTER_TEST_EN
    logic [7:0] echo_ref_q, echo_ref_d;
`endif

    // Next-state: sequencing of TURN/CMD/WR/RWAIT/RD/GAP and byte counting.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_d = req_cmd;
                    if (!cmd_ok(req_cmd)) begin
                        state_d = S_ERR;
                    end else if (last_rd_q) begin
                        state_d = S_TURN;
                    end else begin
                        state_d = S_CMD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: state_d = S_CMD;
            S_CMD: begin
                cnt_d = 5'd0;
                if (wr_len(cmd_q) != 5'd0) begin
                    state_d = S_WR;
                end else if (rd_len(cmd_q) != 5'd0) begin
                    state_d = S_RWAIT;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_WR: begin
                // cmd 0 goes straight to RD: the echo is driven from the edge ending WR
                if (cnt_q == wr_len(cmd_q) - 5'd1) begin
                    cnt_d = 5'd0;
                    if (rd_len(cmd_q) != 5'd0) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_RWAIT: state_d = S_RD;
            S_RD: begin
                if (cnt_q == rd_len(cmd_q) - 5'd1) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_GAP: begin
                last_rd_d = (rd_len(cmd_q) != 5'd0);
                state_d   = S_IDLE;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every port comes straight from a flop.
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        data_sync_d = (state_d == S_TURN) || (state_d == S_CMD);
        bus_oe_d    = data_sync_d || (state_d == S_WR);
        done_d      = (state_d == S_GAP);
        err_d       = (state_d == S_ERR);
        rd_valid_d  = (state_q == S_RD);
        case (state_d)
            S_TURN:  bus_out_d = 8'hFF;
            S_CMD:   bus_out_d = {5'd0, cmd_d};
            S_WR:    bus_out_d = wr_data;
            default: bus_out_d = 8'h00;
        endcase
        case (state_d)
            S_CMD:   wr_take_d = (wr_len(cmd_d) != 5'd0);
            S_WR:    wr_take_d = (cnt_d != wr_len(cmd_d) - 5'd1);
            default: wr_take_d = 1'b0;
        endcase
        if (state_q == S_RD) begin
            rd_data_d = bus_in;
        end else begin
            rd_data_d = rd_data_q;
        end
`ifdef BUS_MASTER_TEST_EN
        if (state_q == S_WR) begin
            echo_ref_d = bus_out_q;
        end else begin
            echo_ref_d = echo_ref_q;
        end
        test_fail_d = (state_q == S_RD) && (cmd_q == 3'd0) && (bus_in != echo_ref_q);
`else
        test_fail_d = 1'b0;
`endif
    end

    // State and output registers; last_rd resets high so the first transaction turns the bus.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= 3'd0;
            cnt_q       <= 5'd0;
            last_rd_q   <= 1'b1;
            req_ready_q <= 1'b0;
            wr_take_q   <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            test_fail_q <= 1'b0;
            bus_out_q   <= 8'h00;
            bus_oe_q    <= 1'b0;
            data_sync_q <= 1'b0;
`ifdef BUS_MASTER_TEST_EN
            echo_ref_q  <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            last_rd_q   <= last_rd_d;
            req_ready_q <= req_ready_d;
            wr_take_q   <= wr_take_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            test_fail_q <= test_fail_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
            data_sync_q <= data_sync_d;
`ifdef BUS_MASTER_TEST_EN
            echo_ref_q  <= echo_ref_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign wr_take   = wr_take_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign test_fail = test_fail_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign data_sync = data_sync_q;

endmodule

// File: tb/tb_stm32_bus_master.sv
// Bench for stm32_bus_master: behavioural responder on the bus plus a per-command table model.
module tb_stm32_bus_master;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_cmd;
    logic       req_ready;
    logic [7:0] wr_data;
    logic       wr_take;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       err;
    logic       test_fail;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       data_sync;

    logic [7:0] wbuf [16];
    logic [7:0] rbuf [16];
    int         take_cnt = 0;
    int         wbase = 0;
    logic [3:0] widx;
    logic       resp_oe = 1'b0;
    logic [7:0] resp_data = 8'h00;
    int         rs_k = 0;
    logic [2:0] rs_cmd = 3'd0;
    bit         echo_force = 1'b0;
    logic [7:0] echo_val = 8'h00;
    int         contention = 0;
    int         total = 0;
    int         bad = 0;
    bit         model_last_rd = 1'b1;

    stm32_bus_master dut (
        .clk_in(clk_in), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_ready(req_ready), .wr_data(wr_data), .wr_take(wr_take), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .err(err), .test_fail(test_fail),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .data_sync(data_sync)
    );

    always #5 clk_in = ~clk_in;

    function automatic int w_len(input logic [2:0] c);
        case (c)
            3'd0: return 1;
            3'd1: return 12;
            3'd3: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int r_len(input logic [2:0] c);
        case (c)
            3'd0: return 1;
            3'd2: return 5;
            3'd4: return 16;
            default: return 0;
        endcase
    endfunction

    function automatic bit valid_cmd(input logic [2:0] c);
`ifdef BUS_MASTER_TEST_EN
        return c != 3'd7;
`else
        return (c != 3'd7) && (c != 3'd0);
`endif
    endfunction

    assign widx    = 4'(take_cnt - wbase);
    assign wr_data = wbuf[widx];
    assign bus_in  = bus_oe ? bus_out : (resp_oe ? resp_data : 8'h00);

    // Local write source: advance one byte per consumed take.
    always @(posedge clk_in) begin
        if (wr_take) take_cnt <= take_cnt + 1;
    end

    // Responder model: counts edges from E0 (edge ending CMD), drives read bytes after Ei.
    always @(posedge clk_in) begin
        if (reset) begin
            resp_oe <= 1'b0;
            rs_k    <= 0;
        end else if (data_sync) begin
            if (bus_out == 8'hFF) begin
                resp_oe <= 1'b0;
            end else begin
                rs_cmd <= bus_out[2:0];
                rs_k   <= 1;
            end
        end else if (rs_k != 0) begin
            if (rs_cmd == 3'd0 && rs_k == 1) begin
                resp_oe   <= 1'b1;
                resp_data <= echo_force ? echo_val : bus_out;
            end else if ((rs_cmd == 3'd2 || rs_cmd == 3'd4) && rs_k <= r_len(rs_cmd)) begin
                resp_oe   <= 1'b1;
                resp_data <= rbuf[4'(rs_k - 1)];
            end
            rs_k <= (rs_k < 20) ? rs_k + 1 : 0;
        end
    end

    // Both ends driving outside the TURN handover cycle is a collision.
    always @(negedge clk_in) begin
        if (bus_oe && resp_oe && !(data_sync && bus_out == 8'hFF)) contention <= contention + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic [2:0] cmd, input bit rnd, input logic [7:0] seed,
                          input bit fe, input logic [7:0] fv);
        bit ok, turn, tf_any, tf_orphan;
        int wl, rl, lat, budget, done_n, err_n, done_cnt, take_n, oe_n, last_rv, nsync;
        logic [7:0] syncq[$];
        logic [7:0] wrq[$];
        logic [7:0] rdq[$];
        logic [7:0] expq[$];
        ok   = valid_cmd(cmd);
        wl   = ok ? w_len(cmd) : 0;
        rl   = ok ? r_len(cmd) : 0;
        turn = ok && model_last_rd;
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = rnd ? 8'($urandom) : seed + 8'(i);
            rbuf[i] = rnd ? 8'($urandom) : seed + 8'(i);
        end
        echo_force = fe;
        echo_val   = fv;
        if (ok && cmd == 3'd0) expq.push_back(fe ? fv : wbuf[0]);
        else for (int i = 0; i < rl; i++) expq.push_back(rbuf[i]);
        lat    = int'(turn) + 1 + wl + ((cmd == 3'd2 || cmd == 3'd4) ? 1 : 0) + rl + 1;
        budget = lat + 6;
        nsync  = ok ? int'(turn) + 1 : 0;
        tf_any = 1'b0; tf_orphan = 1'b0;
        done_n = 0; err_n = 0; done_cnt = 0; take_n = 0; oe_n = 0; last_rv = 0;
        @(negedge clk_in);
        wbase     = take_cnt;
        req_cmd   = cmd;
        req_valid = 1'b1;
        for (int k = 0; k < 40 && !req_ready; k++) @(negedge clk_in);
        check("req_ready_wait", 32'(req_ready), 32'd1);
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk_in);
            req_valid = 1'b0;
            if (data_sync) syncq.push_back(bus_out);
            if (bus_oe) oe_n++;
            if (bus_oe && !data_sync) wrq.push_back(bus_out);
            if (wr_take) take_n++;
            if (rd_valid) begin
                rdq.push_back(rd_data);
                last_rv = n;
            end
            if (test_fail && rd_valid) tf_any = 1'b1;
            if (test_fail && !rd_valid) tf_orphan = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_n == 0) done_n = n;
            end
            if (err && err_n == 0) err_n = n;
            if ((done_n != 0 && n == done_n + 1) || (err_n != 0 && n == err_n + 1)) begin
                check("ready_after_txn", 32'(req_ready), 32'd1);
                break;
            end
        end
        check("sync_cycles", 32'(syncq.size()), 32'(nsync));
        if (ok && syncq.size() == nsync) begin
            if (turn) check("turn_byte", 32'(syncq[0]), 32'hFF);
            check("cmd_byte", 32'(syncq[nsync-1]), 32'(cmd));
        end
        check("oe_cycles", 32'(oe_n), 32'(ok ? int'(turn) + 1 + wl : 0));
        check("wr_count", 32'(wrq.size()), 32'(wl));
        for (int i = 0; i < wrq.size() && i < wl; i++) check("wr_byte", 32'(wrq[i]), 32'(wbuf[i]));
        check("take_count", 32'(take_n), 32'(wl));
        check("rd_count", 32'(rdq.size()), 32'(expq.size()));
        for (int i = 0; i < rdq.size() && i < expq.size(); i++) check("rd_byte", 32'(rdq[i]), 32'(expq[i]));
        check("done_pulses", 32'(done_cnt), 32'(ok ? 1 : 0));
        check("err_cycle", 32'(err_n), 32'(ok ? 0 : 1));
        if (ok) check("latency", 32'(done_n), 32'(lat));
        if (rl > 0) check("done_with_last_rd", 32'(last_rv), 32'(done_n));
        check("test_fail", 32'(tf_any), 32'(ok && cmd == 3'd0 && (fe ? fv : wbuf[0]) != wbuf[0]));
        check("test_fail_orphan", 32'(tf_orphan), 32'd0);
        if (ok) model_last_rd = (rl > 0);
    endtask

    task automatic do_abort();
        bit turn;
        int wr6, done_seen;
        turn      = model_last_rd;
        done_seen = 0;
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        @(negedge clk_in);
        wbase     = take_cnt;
        req_cmd   = 3'd3;
        req_valid = 1'b1;
        for (int k = 0; k < 40 && !req_ready; k++) @(negedge clk_in);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        wr6 = int'(turn) + 1 + 6;
        for (int n = 1; n <= wr6; n++) begin
            @(negedge clk_in);
            req_valid = 1'b0;
            if (done) done_seen++;
        end
        check("abort_wr6_oe", 32'(bus_oe), 32'd1);
        check("abort_wr6_byte", 32'(bus_out), 32'(wbuf[5]));
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        check("abort_oe", 32'(bus_oe), 32'd0);
        check("abort_sync", 32'(data_sync), 32'd0);
        check("abort_outs", 32'({done, rd_valid, wr_take, err, req_ready, bus_out}), 32'd0);
        @(negedge clk_in);
        check("abort_ready", 32'(req_ready), 32'd1);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_in);
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        model_last_rd = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 3'd0;
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = 8'h00;
            rbuf[i] = 8'h00;
        end
        repeat (3) @(negedge clk_in);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_bus", 32'({bus_oe, data_sync, bus_out}), 32'd0);
        check("rst_pulses", 32'({wr_take, rd_valid, done, err, test_fail}), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        @(negedge clk_in);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        do_txn(3'd1, 1'b0, 8'h01, 1'b0, 8'h00);
        do_txn(3'd4, 1'b0, 8'h10, 1'b0, 8'h00);
        do_txn(3'd2, 1'b1, 8'h00, 1'b0, 8'h00);
        do_txn(3'd5, 1'b1, 8'h00, 1'b0, 8'h00);
        do_txn(3'd6, 1'b1, 8'h00, 1'b0, 8'h00);
        do_txn(3'd0, 1'b0, 8'hA5, 1'b0, 8'h00);
        do_txn(3'd0, 1'b0, 8'hA5, 1'b1, 8'h5A);
        do_txn(3'd7, 1'b1, 8'h00, 1'b0, 8'h00);
        do_abort();
        do_txn(3'd3, 1'b1, 8'h00, 1'b0, 8'h00);
        for (int t = 0; t < 24; t++) begin
            do_txn(3'($urandom_range(0, 7)), 1'b1, 8'h00, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        check("bus_contention", 32'(contention), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
